id_ex_stage: RTL and testbench

- ID/EX pipeline register that sits directly upstream of the ALU.
- Captures decoded operands and control from the decode stage under a valid/ready handshake.
- Resolves data hazards by forwarding from the EX/MEM and MEM/WB stages.
- Drives the ALU operands a and b and the 3-bit ALU opcode aluc.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/id_ex_stage_fwd_mux.sv | 34 +++
 rtl/id_ex_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, forwarding-source selects, register-zero address.
package cpu_pkg;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_OR  = 3'b010;
    localparam logic [2:0] ALUC_SLL = 3'b011;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: picks the newest value of one source register; EX/MEM beats MEM/WB, r0 never forwards.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic [RW-1:0] addr,
    input  logic [DW-1:0] reg_val,
    input  logic          exmem_we,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_data,
    input  logic          memwb_we,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] value,
    output fwd_sel_e      sel
);

    always_comb begin
        sel   = FWD_REG;
        value = reg_val;
        if (addr != RW'(REG_ZERO)) begin
            if (exmem_we && (exmem_rd == addr)) begin
                sel   = FWD_EXMEM;
                value = exmem_data;
            end else if (memwb_we && (memwb_rd == addr)) begin
                sel   = FWD_MEMWB;
                value = memwb_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with valid/ready handshake and flush.
// Define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB forwarding with stall capture.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_rs_data,
    input  logic [DW-1:0] in_rt_data,
    input  logic [DW-1:0] in_imm,
    input  logic [4:0]    in_shamt,
    input  logic [RW-1:0] in_rs,
    input  logic [RW-1:0] in_rt,
    input  logic [RW-1:0] in_rd,
    input  logic [2:0]    in_aluc,
    input  logic          in_alusrc,
    input  logic          in_shift,
    input  logic          in_reg_write,
    input  logic          flush,
    input  logic          exmem_we,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_data,
    input  logic          memwb_we,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_aluc,
    output logic [DW-1:0] out_rt_data,
    output logic [RW-1:0] out_rd,
    output logic          out_reg_write
);

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic          valid_q;
    logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
    logic [4:0]    shamt_q;
    logic [RW-1:0] rs_q, rt_q, rd_q;
    logic [2:0]    aluc_q;
    logic          alusrc_q, shift_q, reg_write_q;

    logic [DW-1:0] rs_fwd, rt_fwd;
    fwd_sel_e      rs_sel, rt_sel;
    logic          fwd_exmem_we, fwd_memwb_we;

    // Gating the write enables keeps the mux structure identical in both builds;
    // with forwarding disabled every select stays FWD_REG.
    assign fwd_exmem_we = exmem_we & FWD_EN;
    assign fwd_memwb_we = memwb_we & FWD_EN;

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .addr       (rs_q),
        .reg_val    (rs_data_q),
        .exmem_we   (fwd_exmem_we),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_data),
        .memwb_we   (fwd_memwb_we),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .value      (rs_fwd),
        .sel        (rs_sel)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .addr       (rt_q),
        .reg_val    (rt_data_q),
        .exmem_we   (fwd_exmem_we),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_data),
        .memwb_we   (fwd_memwb_we),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .value      (rt_fwd),
        .sel        (rt_sel)
    );

    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            shamt_q     <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            aluc_q      <= '0;
            alusrc_q    <= 1'b0;
            shift_q     <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q     <= 1'b1;
            rs_data_q   <= in_rs_data;
            rt_data_q   <= in_rt_data;
            imm_q       <= in_imm;
            shamt_q     <= in_shamt;
            rs_q        <= in_rs;
            rt_q        <= in_rt;
            rd_q        <= in_rd;
            aluc_q      <= in_aluc;
            alusrc_q    <= in_alusrc;
            shift_q     <= in_shift;
            reg_write_q <= in_reg_write;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            // Stalled: latch any forwarded value so a retiring producer is not lost.
            if (rs_sel != FWD_REG) rs_data_q <= rs_fwd;
            if (rt_sel != FWD_REG) rt_data_q <= rt_fwd;
        end
    end

    assign out_valid     = valid_q;
    assign alu_a         = shift_q ? {{(DW-5){1'b0}}, shamt_q} : rs_fwd;
    assign alu_b         = alusrc_q ? imm_q : rt_fwd;
    assign alu_aluc      = aluc_q;
    assign out_rt_data   = rt_fwd;
    assign out_rd        = rd_q;
    assign out_reg_write = valid_q & reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_FORWARD_EN.
module tb_id_ex_stage;
    import cpu_pkg::*;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_rs_data, in_rt_data, in_imm;
    logic [4:0]  in_shamt, in_rs, in_rt, in_rd;
    logic [2:0]  in_aluc;
    logic        in_alusrc, in_shift, in_reg_write, flush;
    logic        exmem_we, memwb_we;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_data, memwb_data;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b, out_rt_data;
    logic [2:0]  alu_aluc;
    logic [4:0]  out_rd;
    logic        out_reg_write;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs_data    (in_rs_data),
        .in_rt_data    (in_rt_data),
        .in_imm        (in_imm),
        .in_shamt      (in_shamt),
        .in_rs         (in_rs),
        .in_rt         (in_rt),
        .in_rd         (in_rd),
        .in_aluc       (in_aluc),
        .in_alusrc     (in_alusrc),
        .in_shift      (in_shift),
        .in_reg_write  (in_reg_write),
        .flush         (flush),
        .exmem_we      (exmem_we),
        .exmem_rd      (exmem_rd),
        .exmem_data    (exmem_data),
        .memwb_we      (memwb_we),
        .memwb_rd      (memwb_rd),
        .memwb_data    (memwb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_aluc      (alu_aluc),
        .out_rt_data   (out_rt_data),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] rs, input logic [31:0] rs_data,
                           input logic [4:0] rt, input logic [31:0] rt_data,
                           input logic [4:0] rd, input logic [2:0] aluc,
                           input logic alusrc, input logic shift,
                           input logic [31:0] imm, input logic [4:0] shamt);
        in_valid     = 1'b1;
        in_rs        = rs;
        in_rs_data   = rs_data;
        in_rt        = rt;
        in_rt_data   = rt_data;
        in_rd        = rd;
        in_aluc      = aluc;
        in_alusrc    = alusrc;
        in_shift     = shift;
        in_imm       = imm;
        in_shamt     = shamt;
        in_reg_write = 1'b1;
    endtask

    task automatic fwd_clear();
        exmem_we = 1'b0; exmem_rd = '0; exmem_data = '0;
        memwb_we = 1'b0; memwb_rd = '0; memwb_data = '0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        in_rs_data = '0; in_rt_data = '0; in_imm = '0; in_shamt = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; in_aluc = '0;
        in_alusrc = 1'b0; in_shift = 1'b0; in_reg_write = 1'b0;
        fwd_clear();
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_a", alu_a, 32'd0);
        check("rst_b", alu_b, 32'd0);
        check("rst_rw", 32'(out_reg_write), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        // Simple add, then drain.
        present(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, ALUC_ADD, 1'b0, 1'b0, 32'd0, 5'd0);
        step();
        in_valid = 1'b0;
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_a", alu_a, 32'd5);
        check("add_b", alu_b, 32'd7);
        check("add_aluc", 32'(alu_aluc), 32'(ALUC_ADD));
        check("add_rd", 32'(out_rd), 32'd3);
        check("add_rw", 32'(out_reg_write), 32'd1);
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_rw", 32'(out_reg_write), 32'd0);

        // Forward priority on rs=3.
        present(5'd3, 32'h11, 5'd4, 32'h22, 5'd5, ALUC_OR, 1'b0, 1'b0, 32'd0, 5'd0);
        step();
        in_valid = 1'b0;
        exmem_we = 1'b1; exmem_rd = 5'd3; exmem_data = 32'hAA;
        memwb_we = 1'b1; memwb_rd = 5'd3; memwb_data = 32'hBB;
        #1;
        check("fwd_exmem", alu_a, FWD ? 32'hAA : 32'h11);
        check("fwd_rt_none", out_rt_data, 32'h22);
        exmem_we = 1'b0;
        #1;
        check("fwd_memwb", alu_a, FWD ? 32'hBB : 32'h11);
        memwb_rd = 5'd4;
        #1;
        check("fwd_rt_memwb", alu_b, FWD ? 32'hBB : 32'h22);
        fwd_clear();
        present(5'd0, 32'h55, 5'd4, 32'h22, 5'd5, ALUC_OR, 1'b0, 1'b0, 32'd0, 5'd0);
        step();
        in_valid = 1'b0;
        exmem_we = 1'b1; exmem_rd = 5'd0; exmem_data = 32'hAA;
        memwb_we = 1'b1; memwb_rd = 5'd0; memwb_data = 32'hBB;
        #1;
        check("fwd_r0", alu_a, 32'h55);
        fwd_clear();
        step();

        // Stall capture on rt=6.
        present(5'd7, 32'd1, 5'd6, 32'h9, 5'd8, ALUC_SUB, 1'b0, 1'b0, 32'd0, 5'd0);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        memwb_we = 1'b1; memwb_rd = 5'd6; memwb_data = 32'h1234;
        #1;
        check("stall_fwd", alu_b, FWD ? 32'h1234 : 32'h9);
        check("stall_ready", 32'(in_ready), 32'd0);
        step();
        memwb_we = 1'b0;
        #1;
        check("stall_hold1", alu_b, FWD ? 32'h1234 : 32'h9);
        check("stall_store", out_rt_data, FWD ? 32'h1234 : 32'h9);
        step();
        check("stall_hold2", alu_b, FWD ? 32'h1234 : 32'h9);
        check("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        fwd_clear();
        step();
        check("stall_drain", 32'(out_valid), 32'd0);

        // Flush beats a simultaneous load.
        present(5'd1, 32'd1, 5'd2, 32'd2, 5'd9, ALUC_ADD, 1'b0, 1'b0, 32'd0, 5'd0);
        step();
        check("pre_flush_rw", 32'(out_reg_write), 32'd1);
        flush = 1'b1;
        present(5'd1, 32'd3, 5'd2, 32'd4, 5'd10, ALUC_ADD, 1'b0, 1'b0, 32'd0, 5'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_rw", 32'(out_reg_write), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);

        // Shift path, then immediate back-to-back with no bubble.
        present(5'd9, 32'h77, 5'd10, 32'd1, 5'd11, ALUC_SLL, 1'b0, 1'b1, 32'd0, 5'd4);
        step();
        check("sll_a", alu_a, 32'd4);
        check("sll_b", alu_b, 32'd1);
        check("sll_aluc", 32'(alu_aluc), 32'(ALUC_SLL));
        present(5'd12, 32'h100, 5'd13, 32'h5, 5'd14, ALUC_ADD, 1'b1, 1'b0, 32'hFFFF_FFF0, 5'd4);
        #1;
        check("b2b_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("imm_valid", 32'(out_valid), 32'd1);
        check("imm_a", alu_a, 32'h100);
        check("imm_b", alu_b, 32'hFFFF_FFF0);
        check("imm_rtdata", out_rt_data, 32'h5);
        check("imm_rd", 32'(out_rd), 32'd14);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
